// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART TX arbiter slice.
package uart_arb_pkg;
  localparam int BYTE_W  = 8;
  localparam int GRANT_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index when
// UART_ARB_FIXED_PRIO_EN is defined (ptr then ignored).
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] winner,
  output logic               valid
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = GRANT_W'(i);
        valid  = 1'b1;
      end
    end
  end
`else
  // Walk offsets from the highest down so the closest index at/after ptr wins last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pending[i] && ((int'(ptr) + k) % NUM_REQ == i)) begin
          winner = GRANT_W'(i);
          valid  = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ pulse requesters, one byte each.
// Round-robin by default; UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_pulse,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  output logic [GRANT_W-1:0]        grant_id,
  output logic [NUM_REQ-1:0]        pending,
  output logic [NUM_REQ-1:0]        overrun,
  output logic                      err_to
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] overrun_q, overrun_d;
  logic               err_to_q, err_to_d;
  logic [BYTE_W-1:0]  slot_q [NUM_REQ];
  logic [BYTE_W-1:0]  slot_d [NUM_REQ];
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GRANT_W-1:0] pick_id;
  logic               pick_vld;
  logic               grant_fire;
  logic               clr_i;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (pending_q),
    .ptr     (rr_ptr_q),
    .winner  (pick_id),
    .valid   (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    err_to_d   = err_to_q;
    slot_d     = slot_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    grant_fire = 1'b0;
    clr_i      = 1'b0;

    case (state_q)
      IDLE: begin
        // A busy line here belongs to someone else's frame; wait it out.
        if (pick_vld && !tx_busy) begin
          grant_fire = 1'b1;
          grant_id_d = pick_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == GRANT_W'(i)) tx_data_d = slot_q[i];
          end
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GRANT_W'(i)) pending_d[i] = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          rr_ptr_d = (grant_id_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pulse landing on the grant cycle re-arms the slot with its new byte.
    for (int i = 0; i < NUM_REQ; i++) begin
      clr_i = grant_fire && (pick_id == GRANT_W'(i));
      if (clr_i) pending_d[i] = 1'b0;
      if (req_pulse[i]) begin
        if (pending_q[i] && !clr_i) begin
          overrun_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          slot_d[i]    = req_data[BYTE_W*i +: BYTE_W];
        end
      end
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overrun_q  <= '0;
      err_to_q   <= 1'b0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      err_to_q   <= err_to_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
    end
  end

  assign tx_start = (state_q == START) && !rst;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;
  assign err_to   = err_to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised + directed bench for uart_tx_arbiter against a rule-level arbiter model
// and a simple UART TX stand-in. Honours UART_ARB_FIXED_PRIO_EN.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_pulse = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_busy = 1'b0;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [2:0]     grant_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;
  logic           err_to;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .req_data(req_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .pending(pending), .overrun(overrun), .err_to(err_to)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: pending flags, stored bytes, pointer, and the frame in flight.
  logic [N-1:0] m_pend, m_ovr;
  logic [7:0]   m_byte [N];
  logic [7:0]   m_b;
  logic         m_err, m_fly, m_seen;
  int           m_ptr, m_n, m_g;

  // UART TX stand-in.
  bit r_never = 0, r_stale = 0, r_act = 0;
  int r_t = 0, r_len = 5;
  int served[$];
  logic [7:0] sent[$];
  int last_start = 0;
  int err_cyc = -1;

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic step(input logic [N-1:0] p, input logic [8*N-1:0] d, input logic r);
    logic fly0, b, es;
    logic [N-1:0] sp;
    int w;
    req_pulse = p;
    req_data  = d;
    rst       = r;
    tx_busy   = r_stale || (!r_never && r_act && r_t >= 1 && r_t <= r_len);
    b = tx_busy;
    @(posedge clk);
    #1;
    cyc++;
    es = 1'b0;
    if (r) begin
      m_pend = '0; m_ovr = '0; m_err = 1'b0; m_fly = 1'b0; m_ptr = 0; m_seen = 1'b0;
      for (int i = 0; i < N; i++) m_byte[i] = 8'h00;
      r_act = 0;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_pending", pending, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_err_to", err_to, 0);
    end else begin
      sp   = m_pend;
      fly0 = m_fly;
      es   = !fly0 && (sp != '0) && !b;
      w    = pick(sp, m_ptr);
      if (fly0) begin
        m_n++;
        if (!m_seen) begin
          if (m_n >= 2 && b) m_seen = 1'b1;
          else if (m_n == TO + 1) begin
            m_err = 1'b1;
            m_pend[m_g] = 1'b1;
            m_fly = 1'b0;
          end
        end else if (!b) begin
`ifdef UART_ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (m_g + 1) % N;
`endif
          m_fly = 1'b0;
        end
      end
      if (es) begin
        m_pend[w] = 1'b0;
        m_fly = 1'b1; m_n = 0; m_seen = 1'b0; m_g = w; m_b = m_byte[w];
      end
      for (int i = 0; i < N; i++) begin
        if (p[i]) begin
          if (sp[i] && !(es && w == i)) m_ovr[i] = 1'b1;
          else begin
            m_pend[i] = 1'b1;
            m_byte[i] = d[i*8 +: 8];
          end
        end
      end
      chk("tx_start", tx_start, es);
      chk("pending", pending, m_pend);
      chk("overrun", overrun, m_ovr);
      chk("err_to", err_to, m_err);
      if (m_fly) begin
        chk("tx_data", tx_data, m_b);
        chk("grant_id", grant_id, m_g);
      end
    end
    if (err_to && err_cyc < 0) err_cyc = cyc;
    if (tx_start) begin
      r_act = 1; r_t = 0;
      served.push_back(int'(grant_id));
      sent.push_back(tx_data);
      last_start = cyc;
    end else if (r_act) begin
      r_t++;
      if (r_t > r_len) r_act = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step('0, '0, 1'b1);
    served.delete();
    sent.delete();
    err_cyc = -1;
  endtask

  task automatic pulse(input int i, input logic [7:0] v);
    logic [N-1:0]   p;
    logic [8*N-1:0] d;
    p = '0; d = '0;
    p[i] = 1'b1;
    d[i*8 +: 8] = v;
    step(p, d, 1'b0);
  endtask

  task automatic wait_served(input int k, input int budget);
    int base;
    base = served.size();
    for (int c = 0; c < budget && served.size() < base + k; c++) idle(1);
    chk("wait_served", served.size() - base, k);
  endtask

  task automatic wait_quiet(input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      idle(1);
      done = !m_fly && (m_pend == '0) && !r_act && !tx_busy;
    end
    chk("wait_quiet", done, 1);
  endtask

  initial begin
    int pc;
    logic [N-1:0]   p;
    logic [8*N-1:0] d;

    do_reset();
    do_reset();

    // Single request, 100-cycle frame.
    r_len = 100;
    pc = cyc;
    pulse(2, 8'h41);
    wait_served(1, 10);
    chk("s1_latency", last_start - pc, 2);
    chk("s1_gid", served[0], 2);
    chk("s1_data", sent[0], 8'h41);
    wait_quiet(300);
    chk("s1_pending_end", pending, 0);

    // Simultaneous requests, then a second round showing the rotation.
    do_reset();
    r_len = 5;
    step(4'b1011, {8'h13, 8'h00, 8'h11, 8'h10}, 1'b0);
    wait_quiet(200);
    chk("s2_count", served.size(), 3);
    chk("s2_first", served[0], 0);
    chk("s2_second", served[1], 1);
    chk("s2_third", served[2], 3);
    pulse(1, 8'h21);
    wait_quiet(100);
    step(4'b1001, {8'h33, 8'h00, 8'h00, 8'h30}, 1'b0);
    wait_quiet(200);
    chk("s2_round2_count", served.size(), 6);
`ifdef UART_ARB_FIXED_PRIO_EN
    chk("s2_round2_a", served[4], 0);
    chk("s2_round2_b", served[5], 3);
`else
    chk("s2_round2_a", served[4], 3);
    chk("s2_round2_b", served[5], 0);
`endif

    // Overrun on a pending requester.
    do_reset();
    r_len = 20;
    pulse(0, 8'h55);
    pulse(1, 8'hAA);
    idle(5);
    pulse(1, 8'hBB);
    wait_quiet(200);
    chk("s3_overrun", overrun, 4'b0010);
    chk("s3_count", sent.size(), 2);
    chk("s3_byte", sent[1], 8'hAA);

    // Transmitter never answers: timeout, retry, then let it complete.
    do_reset();
    r_never = 1;
    pulse(2, 8'h5C);
    for (int c = 0; c < 60 && err_cyc < 0; c++) idle(1);
    chk("s4_to_delay", err_cyc - last_start, TO + 1);
    chk("s4_repend", pending[2], 1);
    r_never = 0;
    r_len = 10;
    wait_quiet(200);
    chk("s4_tries", served.size(), 2);
    chk("s4_retry_gid", served[1], 2);
    chk("s4_retry_data", sent[1], 8'h5C);
    chk("s4_err_sticky", err_to, 1);

    // Reset in the middle of a frame with two requests pending.
    do_reset();
    r_len = 30;
    pulse(0, 8'h01);
    idle(5);
    step(4'b1010, {8'h03, 8'h00, 8'h02, 8'h00}, 1'b0);
    chk("s5_pend_before", pending, 4'b1010);
    do_reset();
    idle(30);
    chk("s5_no_start", served.size(), 0);

    // Stale busy already high: nothing starts until it drops.
    do_reset();
    r_stale = 1;
    pulse(0, 8'h77);
    idle(10);
    chk("s6_held", served.size(), 0);
    r_stale = 0;
    wait_served(1, 10);
    chk("s6_gid", served[0], 0);
    chk("s6_data", sent[0], 8'h77);
    wait_quiet(100);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      p = '0;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 11) == 0);
      d = {$urandom()};
      if (!r_act) r_len = $urandom_range(1, 8);
      step(p, d, 1'b0);
    end
    wait_quiet(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
